xkcd_skein_sequencer: RTL and testbench

Microcode sequencer that drives the 21-bit `instruction_i` bus of `xkcd_skein_processor`. It fetches microwords from an external synchronous program ROM and issues one processor instruction per cycle. It adds loop, jump, wait-for-ready, wait-for-TX and halt control so the hash/compare/transmit program runs with no host involvement. It sits between the program ROM and the processor and is started and stopped by the top level.

---
 rtl/xkcd_skein_seq_pkg.sv | 27 ++
 rtl/xkcd_skein_sequencer.sv | 90 +++++++++
 tb/tb_xkcd_skein_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xkcd_skein_seq_pkg.sv
// xkcd_skein_seq_pkg: sequencer opcodes, state encoding and microword field layout helpers
package xkcd_skein_seq_pkg;
  typedef enum logic [2:0] {
    OP_NEXT       = 3'd0,
    OP_LOOP_SET   = 3'd1,
    OP_LOOP_END   = 3'd2,
    OP_JUMP       = 3'd3,
    OP_WAIT_READY = 3'd4,
    OP_WAIT_TX    = 3'd5,
    OP_HALT       = 3'd6,
    OP_RSVD       = 3'd7
  } seq_op_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} seq_state_e;
  localparam int INSTR_W = 21;
  localparam int OP_W = 3;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  // Microword layout: {op[2:0], operand[aw-1:0], instr[20:0]}
  function automatic int operand_lsb();
    return INSTR_W;
  endfunction
  function automatic int op_lsb(input int aw);
    return INSTR_W + aw;
  endfunction
  function automatic int word_w(input int aw);
    return INSTR_W + aw + OP_W;
  endfunction
endpackage

// File: rtl/xkcd_skein_sequencer.sv
// xkcd_skein_sequencer: microcode sequencer issuing one processor instruction per cycle
// from an external synchronous ROM, with loop/jump/wait/halt control.
module xkcd_skein_sequencer
  import xkcd_skein_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          nonce_ready_i,
  input  logic                          tx_busy_i,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [word_w(ADDR_WIDTH)-1:0] rom_data_i,
  output logic [INSTR_W-1:0]            instruction_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ADDR_WIDTH-1:0]         pc_o
);
  localparam int OP_LSB = op_lsb(ADDR_WIDTH);
  localparam int OPD_LSB = operand_lsb();
  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
  seq_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, loop_cnt_q, loop_cnt_d;
  logic done_q, done_d;
  seq_op_e op;
  logic [ADDR_WIDTH-1:0] operand;
  logic [INSTR_W-1:0] instr;
  assign op = seq_op_e'(rom_data_i[OP_LSB +: OP_W]);
  assign operand = rom_data_i[OPD_LSB +: ADDR_WIDTH];
  assign instr = rom_data_i[INSTR_W-1:0];
  assign rom_addr_o = pc_d;
  assign pc_o = pc_q;
  assign busy_o = state_q == ST_RUN;
  assign done_o = done_q;
  always_comb begin
    state_d = state_q;
    pc_d = START;
    loop_cnt_d = loop_cnt_q;
    done_d = 1'b0;
    instruction_o = NOP_INSTR;
    if (state_q == ST_IDLE) begin
      if (start_i && !stop_i) state_d = ST_RUN;
    end else if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      instruction_o = instr;
      pc_d = pc_q + 1'b1;
      case (op)
        OP_LOOP_SET: loop_cnt_d = operand;
        OP_LOOP_END: if (loop_cnt_q != '0) begin
          loop_cnt_d = loop_cnt_q - 1'b1;
          pc_d = operand;
        end
        OP_JUMP: pc_d = operand;
        OP_WAIT_READY: if (!nonce_ready_i) begin
          instruction_o = NOP_INSTR;
          pc_d = pc_q;
        end
        OP_WAIT_TX: if (tx_busy_i) begin
          instruction_o = NOP_INSTR;
          pc_d = pc_q;
        end
        // Fetch START_ADDR while halting so a restart sees its first word with no bubble
        OP_HALT: begin
          instruction_o = NOP_INSTR;
          pc_d = START;
          state_d = ST_IDLE;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q <= START;
      loop_cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_xkcd_skein_sequencer.sv
// tb_xkcd_skein_sequencer: directed tests with a registered ROM model; checks mid-cycle on negedge.
module tb_xkcd_skein_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic ready = 1'b0;
  logic txb = 1'b0;
  logic [7:0] rom_addr;
  logic [31:0] rom_data;
  logic [20:0] instr;
  logic busy;
  logic done;
  logic [7:0] pc;
  logic [31:0] rom [256];
  int total = 0;
  int bad = 0;

  xkcd_skein_sequencer #(.ADDR_WIDTH(8), .START_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .nonce_ready_i(ready), .tx_busy_i(txb), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .instruction_o(instr), .busy_o(busy),
    .done_o(done), .pc_o(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [31:0] mw(input logic [2:0] op, input logic [7:0] opd, input logic [20:0] ins);
    return {op, opd, ins};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mw(3'd6, 8'd0, 21'd0);
  endtask

  task automatic load_loop();
    clear_rom();
    rom[0] = mw(3'd1, 8'd2, 21'h00100);
    rom[1] = mw(3'd0, 8'd0, 21'h00005);
    rom[2] = mw(3'd2, 8'd1, 21'h00007);
    rom[3] = mw(3'd6, 8'd0, 21'h00000);
  endtask

  task automatic load_straight();
    clear_rom();
    rom[0] = mw(3'd0, 8'd0, 21'h00011);
    rom[1] = mw(3'd0, 8'd0, 21'h00022);
    rom[2] = mw(3'd0, 8'd0, 21'h00033);
    rom[3] = mw(3'd6, 8'd0, 21'h00000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    if (instr !== 21'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
    if (rom_addr !== 8'd0) begin bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    if (pc !== 8'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_straight();
    logic [20:0] ei [4] = '{21'h11, 21'h22, 21'h33, 21'h0};
    load_straight();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      total += 3;
      if (instr !== ei[i]) begin bad++; $display("FAIL straight_instr c%0d got=%h exp=%h", i, instr, ei[i]); end
      if (busy !== 1'b1) begin bad++; $display("FAIL straight_busy c%0d got=%b exp=1", i, busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL straight_done c%0d got=%b exp=0", i, done); end
    end
    @(negedge clk);
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL straight_done_pulse got=%b exp=1", done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL straight_busy_fall got=%b exp=0", busy); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL straight_done_once got=%b exp=0", done); end
  endtask

  task automatic test_loop();
    logic [20:0] ei [8] = '{21'h100, 21'h5, 21'h7, 21'h5, 21'h7, 21'h5, 21'h7, 21'h0};
    logic [7:0] ea [8] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd0};
    logic [7:0] ep [8] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
    load_loop();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      total += 3;
      if (instr !== ei[i]) begin bad++; $display("FAIL loop_instr c%0d got=%h exp=%h", i, instr, ei[i]); end
      if (rom_addr !== ea[i]) begin bad++; $display("FAIL loop_rom_addr c%0d got=%0d exp=%0d", i, rom_addr, ea[i]); end
      if (pc !== ep[i]) begin bad++; $display("FAIL loop_pc c%0d got=%0d exp=%0d", i, pc, ep[i]); end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL loop_done got=%b exp=1", done); end
  endtask

  task automatic test_wait_ready();
    clear_rom();
    rom[0] = mw(3'd4, 8'd0, 21'h40000);
    ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      total += 3;
      if (instr !== 21'd0) begin bad++; $display("FAIL wready_nop c%0d got=%h exp=0", i, instr); end
      if (pc !== 8'd0) begin bad++; $display("FAIL wready_pc c%0d got=%0d exp=0", i, pc); end
      if (rom_addr !== 8'd0) begin bad++; $display("FAIL wready_addr c%0d got=%0d exp=0", i, rom_addr); end
    end
    @(negedge clk);
    ready = 1'b1;
    #1;
    total += 2;
    if (instr !== 21'h40000) begin bad++; $display("FAIL wready_issue got=%h exp=40000", instr); end
    if (rom_addr !== 8'd1) begin bad++; $display("FAIL wready_advance got=%0d exp=1", rom_addr); end
    @(negedge clk);
    ready = 1'b0;
    total++;
    if (pc !== 8'd1) begin bad++; $display("FAIL wready_pc_after got=%0d exp=1", pc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_tx();
    clear_rom();
    rom[0] = mw(3'd5, 8'd0, 21'h12345);
    rom[1] = mw(3'd5, 8'd0, 21'h00abc);
    txb = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      total += 2;
      if (instr !== 21'd0) begin bad++; $display("FAIL wtx_nop c%0d got=%h exp=0", i, instr); end
      if (pc !== 8'd0) begin bad++; $display("FAIL wtx_pc c%0d got=%0d exp=0", i, pc); end
    end
    @(negedge clk);
    txb = 1'b0;
    #1;
    total++;
    if (instr !== 21'h12345) begin bad++; $display("FAIL wtx_issue got=%h exp=12345", instr); end
    @(negedge clk);
    total += 2;
    if (instr !== 21'h00abc) begin bad++; $display("FAIL wtx_immediate got=%h exp=00abc", instr); end
    if (pc !== 8'd1) begin bad++; $display("FAIL wtx_pc1 got=%0d exp=1", pc); end
    @(negedge clk);
    total++;
    if (instr !== 21'd0) begin bad++; $display("FAIL wtx_halt got=%h exp=0", instr); end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL wtx_done got=%b exp=1", done); end
  endtask

  task automatic test_stop();
    load_loop();
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    total++;
    if (instr !== 21'h5) begin bad++; $display("FAIL stop_pre got=%h exp=5", instr); end
    stop = 1'b1;
    #1;
    total += 2;
    if (instr !== 21'd0) begin bad++; $display("FAIL stop_nop got=%h exp=0", instr); end
    if (rom_addr !== 8'd0) begin bad++; $display("FAIL stop_addr got=%0d exp=0", rom_addr); end
    @(negedge clk);
    stop = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle got=%b exp=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL stop_no_done got=%b exp=0", done); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL stop_no_done2 got=%b exp=0", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (instr !== 21'h100) begin bad++; $display("FAIL stop_restart got=%h exp=100", instr); end
    if (pc !== 8'd0) begin bad++; $display("FAIL stop_restart_pc got=%0d exp=0", pc); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    load_loop();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    if (instr !== 21'd0) begin bad++; $display("FAIL rmid_instr got=%h exp=0", instr); end
    if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", done); end
    if (rom_addr !== 8'd0) begin bad++; $display("FAIL rmid_addr got=%0d exp=0", rom_addr); end
    if (pc !== 8'd0) begin bad++; $display("FAIL rmid_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_back_to_back();
    load_straight();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    total += 2;
    if (instr !== 21'd0) begin bad++; $display("FAIL b2b_halt got=%h exp=0", instr); end
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_halt_busy got=%b exp=1", busy); end
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_ignored got=%b exp=0", busy); end
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
    @(negedge clk);
    start = 1'b0;
    total += 3;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    if (instr !== 21'h11) begin bad++; $display("FAIL b2b_first got=%h exp=11", instr); end
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_clr got=%b exp=0", done); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = mw(3'd3, 8'd255, 21'h00077);
    rom[255] = mw(3'd0, 8'd0, 21'h000ff);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (instr !== 21'h77) begin bad++; $display("FAIL wrap_jump got=%h exp=77", instr); end
    if (rom_addr !== 8'd255) begin bad++; $display("FAIL wrap_target got=%0d exp=255", rom_addr); end
    @(negedge clk);
    total += 3;
    if (pc !== 8'd255) begin bad++; $display("FAIL wrap_pc got=%0d exp=255", pc); end
    if (instr !== 21'hff) begin bad++; $display("FAIL wrap_instr got=%h exp=ff", instr); end
    if (rom_addr !== 8'd0) begin bad++; $display("FAIL wrap_addr got=%0d exp=0", rom_addr); end
    @(negedge clk);
    total += 2;
    if (pc !== 8'd0) begin bad++; $display("FAIL wrap_pc0 got=%0d exp=0", pc); end
    if (instr !== 21'h77) begin bad++; $display("FAIL wrap_again got=%h exp=77", instr); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_straight();
    test_loop();
    test_wait_ready();
    test_wait_tx();
    test_stop();
    test_reset_mid_run();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
